// File: rtl/simple_cache.sv
// Direct-mapped, one-word-per-line, write-through/write-allocate cache between a CPU stage and main memory.
// Read hits are combinational; misses and every write stall the CPU until mem_busy completes the transfer.
module simple_cache #(
  parameter int CACHE_SIZE_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy
);

  localparam int B  = $clog2(CACHE_SIZE_WORDS);
  localparam int TW = 32 - B;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU, DONE} state_t;

  state_t                      state_q;
  logic [31:0]                 addr_q;
  logic [31:0]                 wdata_q;
  logic [CACHE_SIZE_WORDS-1:0] valid_q;
  logic [TW-1:0]               tag_q  [CACHE_SIZE_WORDS];
  logic [31:0]                 data_q [CACHE_SIZE_WORDS];

  logic [B-1:0]  idx;
  logic [B-1:0]  fill_idx;
  logic [TW-1:0] req_tag;
  logic          hit;
  logic          fill_en;

  assign idx      = cpu_address[B-1:0];
  assign req_tag  = cpu_address[31:B];
  assign fill_idx = addr_q[B-1:0];
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

  // Reset in the same cycle as the memory response must not leave a half-written line visible.
  assign fill_en  = !rst && mem_busy && ((state_q == READ_MISS) || (state_q == WRITE_THRU));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_write) begin
            addr_q  <= cpu_address;
            wdata_q <= cpu_write_data;
            state_q <= WRITE_THRU;
          end else if (cpu_read && !hit) begin
            addr_q  <= cpu_address;
            state_q <= READ_MISS;
          end
        end
        READ_MISS, WRITE_THRU: begin
          if (mem_busy) begin
            valid_q[fill_idx] <= 1'b1;
            state_q           <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; validity alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= addr_q[31:B];
      data_q[fill_idx] <= (state_q == WRITE_THRU) ? wdata_q : mem_read_data;
    end
  end

  assign mem_read       = (state_q == READ_MISS);
  assign mem_write      = (state_q == WRITE_THRU);
  assign mem_address    = (mem_read || mem_write) ? addr_q : 32'h0;
  assign mem_write_data = mem_write ? wdata_q : 32'h0;

  always_comb begin
    cpu_stall = 1'b0;
    case (state_q)
      IDLE:       cpu_stall = cpu_write || (cpu_read && !hit);
      READ_MISS:  cpu_stall = 1'b1;
      WRITE_THRU: cpu_stall = 1'b1;
      DONE:       cpu_stall = 1'b0;
      default:    cpu_stall = 1'b0;
    endcase
  end

  assign cpu_read_data = (((state_q == IDLE) || (state_q == DONE)) && cpu_read && hit)
                         ? data_q[idx] : 32'h0;

endmodule

// File: tb/tb_simple_cache.sv
// Table-driven bench for simple_cache with a responsive memory model and a read-data scoreboard.
module tb_simple_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_write_data;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_busy;

  simple_cache #(.CACHE_SIZE_WORDS(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_address    (cpu_address),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .cpu_stall      (cpu_stall),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_busy       (mem_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Memory model: explicit entries, otherwise a fixed address-derived pattern.
  logic [31:0] mem_m [logic [31:0]];
  int          mem_wait = 0;
  int          wait_cnt = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(negedge clk) begin
    if (rst || !(mem_read || mem_write) || mem_busy) begin
      mem_busy      = 1'b0;
      mem_read_data = 32'h0;
      wait_cnt      = 0;
    end else if (wait_cnt >= mem_wait) begin
      mem_busy      = 1'b1;
      mem_read_data = mem_read ? mem_rd(mem_address) : 32'h0;
      if (mem_write) mem_m[mem_address] = mem_write_data;
      wait_cnt      = 0;
    end else begin
      wait_cnt++;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    int          wait_c;
    int          exp_stall;
    logic [31:0] exp_data;
    logic        exp_mrd;
    logic        exp_mwr;
  } vec_t;

  logic [31:0] exp_q [$];

  task automatic run_op(input string nm, input vec_t v);
    int          cyc;
    logic        saw_rd, saw_wr, bad_bus, done;
    logic [31:0] got, expd;
    mem_wait = v.wait_c;
    @(negedge clk);
    cpu_address    = v.addr;
    cpu_read       = v.rd;
    cpu_write      = v.wr;
    cpu_write_data = v.wdata;
    if (v.rd) exp_q.push_back(v.exp_data);
    cyc = 0; saw_rd = 0; saw_wr = 0; bad_bus = 0; done = 0;
    while (!done) begin
      #2;
      if (mem_read && mem_write) bad_bus = 1;
      if ((mem_read || mem_write) && mem_address !== v.addr) bad_bus = 1;
      if (mem_write && mem_write_data !== v.wdata) bad_bus = 1;
      if (mem_read)  saw_rd = 1;
      if (mem_write) saw_wr = 1;
      if (!cpu_stall || cyc >= 200) done = 1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    got = cpu_read_data;
    chk({nm, " completes"}, {31'h0, cpu_stall}, 32'h0);
    if (v.rd) begin
      expd = exp_q.pop_front();
      chk({nm, " read_data"}, got, expd);
    end
    chk({nm, " stall_cycles"}, cyc, v.exp_stall);
    chk({nm, " mem_read_seen"}, {31'h0, saw_rd}, {31'h0, v.exp_mrd});
    chk({nm, " mem_write_seen"}, {31'h0, saw_wr}, {31'h0, v.exp_mwr});
    chk({nm, " bus_stable"}, {31'h0, bad_bus}, 32'h0);
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  vec_t tbl [13];
  vec_t post [3];

  initial begin
    tbl[0]  = '{32'd5,     1'b1, 1'b0, 32'h0,         0, 2, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[1]  = '{32'd5,     1'b1, 1'b0, 32'h0,         0, 0, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = '{32'd261,   1'b1, 1'b0, 32'h0,         0, 2, 32'hCAFEF00D, 1'b1, 1'b0};
    tbl[3]  = '{32'd5,     1'b1, 1'b0, 32'h0,         0, 2, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[4]  = '{32'd7,     1'b0, 1'b1, 32'h12345678,  0, 2, 32'h0,        1'b0, 1'b1};
    tbl[5]  = '{32'd7,     1'b1, 1'b0, 32'h0,         0, 0, 32'h12345678, 1'b0, 1'b0};
    tbl[6]  = '{32'd300,   1'b1, 1'b0, 32'h0,         4, 6, 32'h5A5A012C, 1'b1, 1'b0};
    tbl[7]  = '{32'd9,     1'b1, 1'b1, 32'hA5A5A5A5,  0, 2, 32'hA5A5A5A5, 1'b0, 1'b1};
    tbl[8]  = '{32'd9,     1'b1, 1'b0, 32'h0,         0, 0, 32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[9]  = '{32'd263,   1'b1, 1'b0, 32'h0,         1, 3, 32'h5A5A0107, 1'b1, 1'b0};
    tbl[10] = '{32'd7,     1'b1, 1'b0, 32'h0,         0, 2, 32'h12345678, 1'b1, 1'b0};
    tbl[11] = '{32'h100,   1'b0, 1'b1, 32'h0F0F1234,  2, 4, 32'h0,        1'b0, 1'b1};
    tbl[12] = '{32'h100,   1'b1, 1'b0, 32'h0,         0, 0, 32'h0F0F1234, 1'b0, 1'b0};
    post[0] = '{32'd5,     1'b1, 1'b0, 32'h0,         0, 2, 32'hDEADBEEF, 1'b1, 1'b0};
    post[1] = '{32'd7,     1'b1, 1'b0, 32'h0,         0, 2, 32'h12345678, 1'b1, 1'b0};
    post[2] = '{32'd517,   1'b1, 1'b0, 32'h0,         0, 2, 32'h5A5A0205, 1'b1, 1'b0};

    mem_m[32'd5]   = 32'hDEADBEEF;
    mem_m[32'd261] = 32'hCAFEF00D;

    rst = 1'b1;
    cpu_address = 32'h0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset cpu_stall",      {31'h0, cpu_stall}, 32'h0);
    chk("reset mem_read",       {31'h0, mem_read},  32'h0);
    chk("reset mem_write",      {31'h0, mem_write}, 32'h0);
    chk("reset mem_address",    mem_address,        32'h0);
    chk("reset mem_write_data", mem_write_data,     32'h0);
    chk("reset cpu_read_data",  cpu_read_data,      32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    // Reset while a miss to 517 is waiting on memory.
    mem_wait = 50;
    @(negedge clk);
    cpu_address = 32'd517;
    cpu_read    = 1'b1;
    #2;
    chk("rstmid detect stall", {31'h0, cpu_stall}, 32'h1);
    @(negedge clk);
    #2;
    chk("rstmid mem_read",    {31'h0, mem_read}, 32'h1);
    chk("rstmid mem_address", mem_address,       32'd517);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid mem_read dropped", {31'h0, mem_read}, 32'h0);
    chk("rstmid mem_address zero", mem_address,       32'h0);
    @(negedge clk);
    rst      = 1'b0;
    cpu_read = 1'b0;
    mem_wait = 0;

    for (int i = 0; i < 3; i++) run_op($sformatf("post%0d", i), post[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
